// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-side types and constants.
//   word_t                   - 8-bit data word held by the call stack
//   CALL_STACK_DEPTH_DEFAULT - default number of call-stack entries
package cpu_pkg;

    typedef logic [7:0] word_t;

    localparam int CALL_STACK_DEPTH_DEFAULT = 16;

endpackage : cpu_pkg

// File: rtl/stack_pointer.sv
// stack_pointer: saturating up/down counter holding the number of stack entries.
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high; clears count to 0
//   inc   - count up by one (held at DEPTH when already there)
//   dec   - count down by one (held at 0 when already there)
//   count - current entry count, 0..DEPTH
//
// inc and dec together cancel out, so count never wraps between 0 and DEPTH.
module stack_pointer #(
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && (count != CW'(DEPTH))) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule : stack_pointer

// File: rtl/call_stack.sv
// call_stack: LIFO of DEPTH 8-bit words (return addresses / saved registers).
//
// Ports:
//   clock     - rising-edge clock for all state
//   reset     - synchronous, active-high; wins over push/pop in the same cycle
//   push      - place datain on top of stack this cycle
//   pop       - remove top entry this cycle
//   datain    - value to push
//   dataout   - top-of-stack value, 8'h00 while empty (combinational)
//   empty     - no entries held
//   full      - DEPTH entries held
//   count     - number of entries held
//   overflow  - sticky: push attempted while full
//   underflow - sticky: pop attempted while empty
//
// push and pop are level requests sampled on every rising edge; there is no
// ready/backpressure. Requests that cannot be honoured (push while full, pop
// while empty) are dropped and, in the flag build, recorded in the sticky flags.
// push+pop on a non-empty stack exchanges the top entry; on an empty stack it
// acts as a plain push.
//
// Build option: define CALL_STACK_ERROR_FLAGS_EN to implement the sticky
// overflow/underflow registers. Without it both ports are tied to 0.
module call_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = CALL_STACK_DEPTH_DEFAULT,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  word_t         datain,
    output word_t         dataout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    word_t         mem [DEPTH];
    logic          do_push;
    logic          do_pop;
    logic          do_xchg;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Full cannot coincide with empty (DEPTH >= 2), so push+pop while full is
    // an exchange and push+pop while empty is a push.
    assign do_push = push && (!pop || empty) && !full;
    assign do_pop  = pop && !push && !empty;
    assign do_xchg = push && pop && !empty;

    assign top_idx = AW'(count - 1'b1);
    assign wr_en   = do_push || do_xchg;
    assign wr_idx  = do_push ? AW'(count) : top_idx;

    stack_pointer #(
        .DEPTH (DEPTH)
    ) u_stack_pointer (
        .clock (clock),
        .reset (reset),
        .inc   (do_push),
        .dec   (do_pop),
        .count (count)
    );

    // Storage is not reset; entries above count are stale and never read
    // because dataout is forced to zero while empty and only ever indexes
    // below count.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem[wr_idx] <= datain;
        end
    end

    assign dataout = empty ? word_t'(8'h00) : mem[top_idx];

`ifdef CALL_STACK_ERROR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && !pop && full) begin
                overflow_q <= 1'b1;
            end
            if (pop && !push && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule : call_stack

// File: tb/tb_call_stack.sv
// tb_call_stack: self-checking bench for call_stack (DEPTH = 16).
// Directed table, hand-written full/overflow/reset sequences, then random
// traffic against a queue-based LIFO model.
module tb_call_stack;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef CALL_STACK_ERROR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [7:0]    datain;
    logic [7:0]    dataout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    always #5 clock = ~clock;

    call_stack #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .datain    (datain),
        .dataout   (dataout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [7:0] model_q[$];
    bit         m_ovf;
    bit         m_udf;

    function automatic void model_step(input bit r, input bit pu, input bit po, input logic [7:0] d);
        if (r) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (pu && po) begin
            if (model_q.size() == 0) model_q.push_back(d);
            else model_q[model_q.size() - 1] = d;
        end else if (pu) begin
            if (model_q.size() == DEPTH) m_ovf = 1'b1;
            else model_q.push_back(d);
        end else if (po) begin
            if (model_q.size() == 0) m_udf = 1'b1;
            else void'(model_q.pop_back());
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit pu, input bit po, input logic [7:0] d);
        @(negedge clock);
        reset  = r;
        push   = pu;
        pop    = po;
        datain = d;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // eo/eu are the flag-build expectations; the no-flag build expects 0.
    task automatic check_all(input string name, input int ec, input logic [7:0] ed,
                             input bit eo, input bit eu);
        cmp({name, "/count"}, 32'(count), 32'(ec));
        cmp({name, "/dataout"}, 32'(dataout), 32'(ed));
        cmp({name, "/empty"}, 32'(empty), 32'(ec == 0));
        cmp({name, "/full"}, 32'(full), 32'(ec == DEPTH));
        cmp({name, "/overflow"}, 32'(overflow), 32'(FLAGS & eo));
        cmp({name, "/underflow"}, 32'(underflow), 32'(FLAGS & eu));
    endtask

    task automatic check_model(input string name);
        logic [7:0] ed;
        ed = (model_q.size() == 0) ? 8'h00 : model_q[model_q.size() - 1];
        check_all(name, model_q.size(), ed, m_ovf, m_udf);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string      name;
        bit         rst;
        bit         pu;
        bit         po;
        logic [7:0] din;
        int         exp_count;
        logic [7:0] exp_dout;
        bit         exp_ovf;
        bit         exp_udf;
    } vec_t;

    vec_t vecs[16];

    initial begin
        reset  = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        datain = 8'h00;

        vecs[0]  = '{"reset",        1, 0, 0, 8'h00, 0, 8'h00, 0, 0};
        vecs[1]  = '{"push10",       0, 1, 0, 8'h10, 1, 8'h10, 0, 0};
        vecs[2]  = '{"push20",       0, 1, 0, 8'h20, 2, 8'h20, 0, 0};
        vecs[3]  = '{"push30",       0, 1, 0, 8'h30, 3, 8'h30, 0, 0};
        vecs[4]  = '{"pop_to20",     0, 0, 1, 8'h00, 2, 8'h20, 0, 0};
        vecs[5]  = '{"reset_mid",    1, 0, 0, 8'h00, 0, 8'h00, 0, 0};
        vecs[6]  = '{"pop_empty",    0, 0, 1, 8'h00, 0, 8'h00, 0, 1};
        vecs[7]  = '{"reset_udf",    1, 0, 0, 8'h00, 0, 8'h00, 0, 0};
        vecs[8]  = '{"pushpop_emp",  0, 1, 1, 8'h55, 1, 8'h55, 0, 0};
        vecs[9]  = '{"pop_to_emp",   0, 0, 1, 8'h00, 0, 8'h00, 0, 0};
        vecs[10] = '{"pushAA",       0, 1, 0, 8'hAA, 1, 8'hAA, 0, 0};
        vecs[11] = '{"pushBB",       0, 1, 0, 8'hBB, 2, 8'hBB, 0, 0};
        vecs[12] = '{"xchgCC",       0, 1, 1, 8'hCC, 2, 8'hCC, 0, 0};
        vecs[13] = '{"pop_toAA",     0, 0, 1, 8'h00, 1, 8'hAA, 0, 0};
        vecs[14] = '{"idle",         0, 0, 0, 8'h77, 1, 8'hAA, 0, 0};
        vecs[15] = '{"reset_end",    1, 1, 0, 8'h99, 0, 8'h00, 0, 0};

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all("por", 0, 8'h00, 0, 0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].pu, vecs[i].po, vecs[i].din);
            check_all(vecs[i].name, vecs[i].exp_count, vecs[i].exp_dout,
                      vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // Fill to full, then push once more while full.
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 1, 0, 8'(i));
        end
        check_all("fill16", DEPTH, 8'h10, 0, 0);
        step(0, 1, 0, 8'hFF);
        check_all("push_full", DEPTH, 8'h10, 1, 0);

        // Exchange while full: not an overflow, top replaced.
        step(0, 1, 1, 8'hE0);
        check_all("xchg_full", DEPTH, 8'hE0, 1, 0);
        step(0, 1, 1, 8'h10);

        // Pop down to 5 entries; storage below top must be intact.
        for (int i = DEPTH; i > 5; i--) begin
            step(0, 0, 1, 8'h00);
            check_all("pop_down", i - 1, 8'(i - 1), 1, 0);
        end

        // Reset and push together with overflow set at count 5.
        step(1, 1, 0, 8'h42);
        check_all("reset_push", 0, 8'h00, 0, 0);

        // Stale storage must not leak: the new push is what shows.
        step(0, 1, 0, 8'h77);
        check_all("post_reset_push", 1, 8'h77, 0, 0);
        step(0, 0, 1, 8'h00);
        check_all("post_reset_pop", 0, 8'h00, 0, 0);

        // ---------------- random traffic ----------------
        model_step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        check_model("rnd_reset");
        for (int n = 0; n < 3000; n++) begin
            bit         r;
            bit         pu;
            bit         po;
            logic [7:0] d;
            int         phase;
            phase = (n / 150) % 3;  // push-heavy, pop-heavy, balanced
            r  = ($urandom_range(0, 199) == 0);
            d  = 8'($urandom);
            if (phase == 0) begin
                pu = ($urandom_range(0, 9) < 8);
                po = ($urandom_range(0, 9) < 2);
            end else if (phase == 1) begin
                pu = ($urandom_range(0, 9) < 2);
                po = ($urandom_range(0, 9) < 8);
            end else begin
                pu = ($urandom_range(0, 1) == 1);
                po = ($urandom_range(0, 1) == 1);
            end
            model_step(r, pu, po, d);
            step(r, pu, po, d);
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule : tb_call_stack

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DEPTH, default 16, number of 8-bit entries; legal range 2..128, power of two not required.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 push  input  1  request to place datain on top of stack this cycle.
REQ-005 pop  input  1  request to remove top entry this cycle.
REQ-006 datain  input  8  value to push (return address / saved register).
REQ-007 dataout  output  8  current top-of-stack value, combinational from storage.
REQ-008 empty  output  1  high when zero entries held.
REQ-009 full  output  1  high when DEPTH entries held.
REQ-010 count  output  $clog2(DEPTH+1)  number of entries held.
REQ-011 overflow  output  1  sticky flag, push attempted while full.
REQ-012 underflow  output  1  sticky flag, pop attempted while empty.

Function
REQ-013 The block SHALL hold a LIFO of DEPTH words and a stack pointer equal to count; all updates on rising clock edge only.
REQ-014 Push only, not full: write datain at index count, count+1 next cycle; dataout shows datain from next cycle.
REQ-015 Pop only, not empty: count-1 next cycle; storage contents unchanged; dataout shows the entry below.
REQ-016 Push and pop together, not empty: overwrite top entry with datain, count unchanged (exchange), no flag set.
REQ-017 Push and pop together while empty: treated as push only; underflow not set.
REQ-018 Push only while full: ignored, storage and count unchanged; overflow set.
REQ-019 Pop only while empty: ignored, count stays 0; underflow set.
REQ-020 dataout SHALL be 8'h00 whenever empty, otherwise entry at index count-1.
REQ-021 empty = (count==0), full = (count==DEPTH), both combinational from count; never both high.
REQ-022 count SHALL never wrap: no transition from 0 to DEPTH or DEPTH to 0 in one cycle.
REQ-023 Neither push nor pop: no state change.

Reset
REQ-024 Reset SHALL have priority over push/pop in the same cycle.
REQ-025 After reset: count=0, empty=1, full=0, dataout=8'h00, overflow=0, underflow=0.
REQ-026 Storage array is not cleared by reset; stale contents SHALL never be visible on dataout.
REQ-027 Reset asserted mid-sequence SHALL discard all entries at the next edge.

Configuration
REQ-028 Macro CALL_STACK_ERROR_FLAGS_EN defined: overflow/underflow behave per REQ-018/019, sticky until reset.
REQ-029 Macro not defined: overflow and underflow ports remain present, tied to 0, no flag registers synthesised; ignore behaviour of REQ-018/019 unchanged.

Structure
REQ-030 Shared package cpu_pkg SHALL hold typedef word_t (logic [7:0]) and constant CALL_STACK_DEPTH_DEFAULT = 16.
REQ-031 Stack pointer SHALL be a sub-module stack_pointer: up/down counter with inc, dec, sync reset, saturation at 0 and DEPTH, output count.
REQ-032 Storage SHALL be a plain register array inferred in call_stack, single write port, single read port.

Verification
REQ-033 Reset, then push 8'h10, 8'h20, 8'h30 -> count=3, dataout=8'h30; pop -> dataout=8'h20, count=2.
REQ-034 DEPTH=16: 16 pushes of 8'h01..8'h10 -> full=1; 17th push 8'hFF -> count=16, dataout=8'h10, overflow=1 (flag build).
REQ-035 Empty, pop -> count=0, dataout=8'h00, underflow=1 (flag build), 0 (no-flag build).
REQ-036 Stack holding 8'hAA,8'hBB: push+pop with datain=8'hCC -> count=2, dataout=8'hCC; pop -> 8'hAA.
REQ-037 Empty, push+pop with datain=8'h55 -> count=1, dataout=8'h55, underflow=0.
REQ-038 Count=5 with overflow=1, reset and push asserted same cycle -> count=0, empty=1, overflow=0, dataout=8'h00.
